// File: rtl/phy_lane_compare_checker_if.sv
// ---------------------------------------------------------------------------
// phy_lane_compare_checker_if
//   Bundles the stimulus and result signals of the lane compare checker.
//   The tester side (master) drives the two model streams plus the enable and
//   skew controls. It reads back the FSM state, error flags, counters and the
//   first-failure capture. The checker uses the slave modport.
//
//   enable           master->slave  run checker (0 = return to IDLE)
//   skew             master->slave  behavioural-side delay, sampled on arm
//   in_b / valid_b   master->slave  behavioural data / per-lane valid
//   in_s / valid_s   master->slave  structural data / per-lane valid
//   state            slave->master  0 IDLE, 1 ARMED, 2 CHECK, 3 HALT
//   err_now          slave->master  error on the compared cycle (pulse)
//   err_sticky       slave->master  any error since arming
//   err_lane_mask    slave->master  sticky per-lane error flags
//   compare_cnt      slave->master  compared cycles (saturating)
//   mismatch_cnt     slave->master  cycles with a failing lane (saturating)
//   first_fail_lane  slave->master  lowest failing lane of the first error
//   first_fail_cycle slave->master  compare_cnt value at the first error
// ---------------------------------------------------------------------------
interface phy_lane_compare_checker_if #(
    parameter int LANES    = 4,
    parameter int WIDTH    = 8,
    parameter int SKEW_MAX = 7,
    parameter int CNT_W    = 16
);
    localparam int SKEW_W = $clog2(SKEW_MAX + 1);
    localparam int LANE_W = $clog2(LANES);

    logic                     enable;
    logic [SKEW_W-1:0]        skew;
    logic [LANES*WIDTH-1:0]   in_b;
    logic [LANES-1:0]         valid_b;
    logic [LANES*WIDTH-1:0]   in_s;
    logic [LANES-1:0]         valid_s;

    logic [1:0]               state;
    logic                     err_now;
    logic                     err_sticky;
    logic [LANES-1:0]         err_lane_mask;
    logic [CNT_W-1:0]         compare_cnt;
    logic [CNT_W-1:0]         mismatch_cnt;
    logic [LANE_W-1:0]        first_fail_lane;
    logic [CNT_W-1:0]         first_fail_cycle;

    modport master (
        output enable, skew, in_b, valid_b, in_s, valid_s,
        input  state, err_now, err_sticky, err_lane_mask, compare_cnt,
               mismatch_cnt, first_fail_lane, first_fail_cycle
    );

    modport slave (
        input  enable, skew, in_b, valid_b, in_s, valid_s,
        output state, err_now, err_sticky, err_lane_mask, compare_cnt,
               mismatch_cnt, first_fail_lane, first_fail_cycle
    );
endinterface

// File: rtl/phy_lane_compare_checker.sv
// ---------------------------------------------------------------------------
// phy_lane_compare_checker
//   Lane-by-lane, cycle-by-cycle comparator between a behavioural and a
//   structural PHY TX model. The behavioural stream passes through a
//   programmable delay line so that a structural model with pipeline latency
//   can be lined up against it. Results are registered, so they appear one
//   clock after the compared beat reaches the delay tap.
//
//   Ports
//     clk    single clock, all logic on posedge
//     reset  synchronous, active-high, overrides everything
//     bus    phy_lane_compare_checker_if.slave (streams, controls, results)
// ---------------------------------------------------------------------------
module phy_lane_compare_checker #(
    parameter int LANES        = 4,
    parameter int WIDTH        = 8,
    parameter int SKEW_MAX     = 7,
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    phy_lane_compare_checker_if.slave   bus
);
    localparam int SKEW_W = $clog2(SKEW_MAX + 1);
    localparam int LANE_W = $clog2(LANES);
    localparam int DW     = LANES * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [LANES-1:0] valid;
    } beat_t;

    state_e              state_q, state_d;
    logic [SKEW_W-1:0]   skew_q, skew_d;
    beat_t               dl_q [SKEW_MAX];
    beat_t               dl_d [SKEW_MAX];
    logic                err_now_q, err_now_d;
    logic                err_sticky_q, err_sticky_d;
    logic [LANES-1:0]    err_lane_mask_q, err_lane_mask_d;
    logic [CNT_W-1:0]    compare_cnt_q, compare_cnt_d;
    logic [CNT_W-1:0]    mismatch_cnt_q, mismatch_cnt_d;
    logic [LANE_W-1:0]   first_fail_lane_q, first_fail_lane_d;
    logic [CNT_W-1:0]    first_fail_cycle_q, first_fail_cycle_d;

    beat_t               tap [SKEW_MAX+1];
    beat_t               dbeat;
    logic [SKEW_W-1:0]   skew_clamped;
    logic [LANES-1:0]    lane_fail;
    logic                any_valid;
    logic [LANE_W-1:0]   low_lane;
    logic                do_compare;
    logic                clear_run;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Tap 0 is the live behavioural input; tap k is the input from k cycles ago.
    always_comb begin
        tap[0] = '{data: bus.in_b, valid: bus.valid_b};
        for (int k = 1; k <= SKEW_MAX; k++) begin
            tap[k] = dl_q[k-1];
        end
    end

    assign dbeat        = tap[skew_q];
    assign skew_clamped = (int'(bus.skew) > SKEW_MAX) ? SKEW_W'(SKEW_MAX) : bus.skew;

    // Lane verdicts. A valid mismatch always fails. Data is only compared when
    // both sides are valid, so idle lanes never raise an error.
    always_comb begin
        lane_fail = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_fail[i] = (bus.valid_s[i] != dbeat.valid[i]) ||
                           (bus.valid_s[i] && dbeat.valid[i] &&
                            (bus.in_s[i*WIDTH +: WIDTH] != dbeat.data[i*WIDTH +: WIDTH]));
        end
        any_valid = (|bus.valid_s) || (|dbeat.valid);
        // Walk from the top lane down so the lowest failing lane wins.
        low_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_fail[i]) low_lane = LANE_W'(i);
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d            = state_q;
        skew_d             = skew_q;
        err_now_d          = 1'b0;
        err_sticky_d       = err_sticky_q;
        err_lane_mask_d    = err_lane_mask_q;
        compare_cnt_d      = compare_cnt_q;
        mismatch_cnt_d     = mismatch_cnt_q;
        first_fail_lane_d  = first_fail_lane_q;
        first_fail_cycle_d = first_fail_cycle_q;
        do_compare         = 1'b0;
        clear_run          = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d   = ARMED;
                    skew_d    = skew_clamped;
                    clear_run = 1'b1;
                end
            end
            ARMED: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (any_valid) begin
                    // The beat that wakes the checker is compared as well.
                    do_compare = 1'b1;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (!bus.enable) state_d = IDLE;
                else             do_compare = any_valid;
            end
            HALT: begin
                if (!bus.enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (do_compare) begin
            compare_cnt_d = sat_inc(compare_cnt_q);
            if (|lane_fail) begin
                err_now_d       = 1'b1;
                err_sticky_d    = 1'b1;
                err_lane_mask_d = err_lane_mask_q | lane_fail;
                mismatch_cnt_d  = sat_inc(mismatch_cnt_q);
                // The capture uses the pre-increment count, so it is 0-based.
                if (!err_sticky_q) begin
                    first_fail_lane_d  = low_lane;
                    first_fail_cycle_d = compare_cnt_q;
                end
                if (STOP_ON_FAIL) state_d = HALT;
            end
        end

        if (clear_run) begin
            err_sticky_d       = 1'b0;
            err_lane_mask_d    = '0;
            compare_cnt_d      = '0;
            mismatch_cnt_d     = '0;
            first_fail_lane_d  = '0;
            first_fail_cycle_d = '0;
        end

        dl_d[0] = tap[0];
        for (int k = 1; k < SKEW_MAX; k++) begin
            dl_d[k] = dl_q[k-1];
        end
        // Arming flushes stale beats so the first compare never sees old data.
        if (clear_run) begin
            for (int k = 0; k < SKEW_MAX; k++) begin
                dl_d[k] = '0;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            skew_q             <= '0;
            err_now_q          <= 1'b0;
            err_sticky_q       <= 1'b0;
            err_lane_mask_q    <= '0;
            compare_cnt_q      <= '0;
            mismatch_cnt_q     <= '0;
            first_fail_lane_q  <= '0;
            first_fail_cycle_q <= '0;
            // NOTE: the delay line is a storage array, but it is reset here
            // because a stale valid would be compared as a real beat.
            for (int k = 0; k < SKEW_MAX; k++) begin
                dl_q[k] <= '0;
            end
        end else begin
            state_q            <= state_d;
            skew_q             <= skew_d;
            err_now_q          <= err_now_d;
            err_sticky_q       <= err_sticky_d;
            err_lane_mask_q    <= err_lane_mask_d;
            compare_cnt_q      <= compare_cnt_d;
            mismatch_cnt_q     <= mismatch_cnt_d;
            first_fail_lane_q  <= first_fail_lane_d;
            first_fail_cycle_q <= first_fail_cycle_d;
            dl_q               <= dl_d;
        end
    end

    assign bus.state            = state_q;
    assign bus.err_now          = err_now_q;
    assign bus.err_sticky       = err_sticky_q;
    assign bus.err_lane_mask    = err_lane_mask_q;
    assign bus.compare_cnt      = compare_cnt_q;
    assign bus.mismatch_cnt     = mismatch_cnt_q;
    assign bus.first_fail_lane  = first_fail_lane_q;
    assign bus.first_fail_cycle = first_fail_cycle_q;
endmodule

// File: tb/tb_phy_lane_compare_checker.sv
// ---------------------------------------------------------------------------
// tb_phy_lane_compare_checker
//   Three checker instances share one stimulus stream:
//     main  : defaults (CNT_W=16, STOP_ON_FAIL=0)
//     stop  : STOP_ON_FAIL=1
//     small : CNT_W=4
//   Each driven cycle, the reference model predicts every instance's outputs
//   after the next clock and queues them. A monitor pops and compares one
//   prediction per clock.
// ---------------------------------------------------------------------------
module tb_phy_lane_compare_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    phy_lane_compare_checker_if #(.LANES(4), .WIDTH(8), .SKEW_MAX(7), .CNT_W(16)) if_main ();
    phy_lane_compare_checker_if #(.LANES(4), .WIDTH(8), .SKEW_MAX(7), .CNT_W(16)) if_stop ();
    phy_lane_compare_checker_if #(.LANES(4), .WIDTH(8), .SKEW_MAX(7), .CNT_W(4))  if_small ();

    phy_lane_compare_checker #(.LANES(4), .WIDTH(8), .SKEW_MAX(7), .CNT_W(16), .STOP_ON_FAIL(1'b0))
        dut_main (.clk(clk), .reset(reset), .bus(if_main));
    phy_lane_compare_checker #(.LANES(4), .WIDTH(8), .SKEW_MAX(7), .CNT_W(16), .STOP_ON_FAIL(1'b1))
        dut_stop (.clk(clk), .reset(reset), .bus(if_stop));
    phy_lane_compare_checker #(.LANES(4), .WIDTH(8), .SKEW_MAX(7), .CNT_W(4), .STOP_ON_FAIL(1'b0))
        dut_small (.clk(clk), .reset(reset), .bus(if_small));

    typedef struct packed {
        logic [1:0]  state;
        logic        err_now;
        logic        err_sticky;
        logic [3:0]  mask;
        logic [15:0] cmp;
        logic [15:0] mis;
        logic [1:0]  ffl;
        logic [15:0] ffc;
    } snap_t;

    typedef struct packed {
        snap_t s_main;
        snap_t s_stop;
        snap_t s_small;
    } trio_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  v;
    } beat_t;

    trio_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_cycle  = 0;

    // Stimulus values applied on the next tick.
    logic        t_reset  = 1'b1;
    logic        t_enable = 1'b0;
    logic [2:0]  t_skew   = 3'd0;
    logic [31:0] t_in_b   = '0;
    logic [31:0] t_in_s   = '0;
    logic [3:0]  t_vb     = '0;
    logic [3:0]  t_vs     = '0;

    // Reference model: index 0 main, 1 stop, 2 small. States use the output
    // codes 0 IDLE, 1 ARMED, 2 CHECK, 3 HALT.
    int    m_st[3], m_cmp[3], m_mis[3], m_ffl[3], m_ffc[3], m_mask[3];
    bit    m_now[3], m_sticky[3];
    int    m_skew = 0;
    beat_t hist[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int cnt_max(input int c);
        return (c == 2) ? 15 : 65535;
    endfunction

    task automatic model_step();
        beat_t cur, db;
        int    fmask, low, old_cmp;
        bit    was_active;
        cur        = '{d: t_in_b, v: t_vb};
        was_active = !t_reset && (m_st[0] != 0);
        // Behavioural beat seen skew cycles ago (zero before arming filled it).
        if (m_skew == 0)                db = cur;
        else if (hist.size() >= m_skew) db = hist[hist.size() - m_skew];
        else                            db = '0;
        fmask = 0;
        for (int i = 0; i < 4; i++) begin
            if (t_vs[i] != db.v[i]) fmask |= (1 << i);
            else if (t_vs[i] && (t_in_s[i*8 +: 8] != db.d[i*8 +: 8])) fmask |= (1 << i);
        end
        low = 0;
        for (int i = 3; i >= 0; i--) if (fmask[i]) low = i;

        for (int c = 0; c < 3; c++) begin
            m_now[c] = 1'b0;
            if (t_reset || (m_st[c] == 0 && t_enable)) begin
                m_st[c]     = t_reset ? 0 : 1;
                m_cmp[c]    = 0;
                m_mis[c]    = 0;
                m_ffl[c]    = 0;
                m_ffc[c]    = 0;
                m_mask[c]   = 0;
                m_sticky[c] = 1'b0;
            end else if (m_st[c] != 0 && !t_enable) begin
                m_st[c] = 0;
            end else if ((m_st[c] == 1 || m_st[c] == 2) && (t_vs != 0 || db.v != 0)) begin
                old_cmp  = m_cmp[c];
                m_cmp[c] = (m_cmp[c] < cnt_max(c)) ? m_cmp[c] + 1 : m_cmp[c];
                if (fmask != 0) begin
                    m_now[c] = 1'b1;
                    if (!m_sticky[c]) begin
                        m_ffl[c] = low;
                        m_ffc[c] = old_cmp;
                    end
                    m_sticky[c] = 1'b1;
                    m_mask[c]   = m_mask[c] | fmask;
                    m_mis[c]    = (m_mis[c] < cnt_max(c)) ? m_mis[c] + 1 : m_mis[c];
                end
                m_st[c] = (fmask != 0 && c == 1) ? 3 : 2;
            end
        end

        if (t_reset) begin
            hist.delete();
        end else if (!was_active) begin
            if (t_enable) begin
                hist.delete();
                m_skew = int'(t_skew);
            end
        end else begin
            hist.push_back(cur);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    function automatic snap_t model_snap(input int c);
        snap_t s;
        s.state      = 2'(m_st[c]);
        s.err_now    = m_now[c];
        s.err_sticky = m_sticky[c];
        s.mask       = 4'(m_mask[c]);
        s.cmp        = 16'(m_cmp[c]);
        s.mis        = 16'(m_mis[c]);
        s.ffl        = 2'(m_ffl[c]);
        s.ffc        = 16'(m_ffc[c]);
        return s;
    endfunction

    // One clock: apply inputs at the falling edge, predict and queue.
    task automatic tick();
        @(negedge clk);
        reset            = t_reset;
        if_main.enable   = t_enable;  if_stop.enable   = t_enable;  if_small.enable   = t_enable;
        if_main.skew     = t_skew;    if_stop.skew     = t_skew;    if_small.skew     = t_skew;
        if_main.in_b     = t_in_b;    if_stop.in_b     = t_in_b;    if_small.in_b     = t_in_b;
        if_main.valid_b  = t_vb;      if_stop.valid_b  = t_vb;      if_small.valid_b  = t_vb;
        if_main.in_s     = t_in_s;    if_stop.in_s     = t_in_s;    if_small.in_s     = t_in_s;
        if_main.valid_s  = t_vs;      if_stop.valid_s  = t_vs;      if_small.valid_s  = t_vs;
        model_step();
        exp_q.push_back('{s_main: model_snap(0), s_stop: model_snap(1), s_small: model_snap(2)});
    endtask

    task automatic idle(input int n);
        t_in_b = '0; t_in_s = '0; t_vb = '0; t_vs = '0;
        repeat (n) tick();
    endtask

    task automatic arm(input int skew);
        t_enable = 1'b0;
        idle(1);
        t_enable = 1'b1;
        t_skew   = 3'(skew);
        idle(1);
    endtask

    function automatic logic [31:0] pattern(input int k);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = 8'(8'h7C + 8'h40 * k + 8'h11 * i);
        return w;
    endfunction

    // Behavioural beats k=0..n-1 start now; structural copies follow lag cycles later.
    task automatic lag_stream(input int lag, input int n);
        for (int j = 0; j < n + lag; j++) begin
            t_in_b = (j < n) ? pattern(j) : '0;
            t_vb   = (j < n) ? 4'hF : 4'h0;
            t_in_s = (j >= lag) ? pattern(j - lag) : '0;
            t_vs   = (j >= lag) ? 4'hF : 4'h0;
            tick();
        end
    endtask

    // Monitor: one prediction per clock, sampled just after the rising edge.
    initial begin
        trio_t e;
        snap_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cycle++;
                a = '{if_main.state, if_main.err_now, if_main.err_sticky, if_main.err_lane_mask,
                      if_main.compare_cnt, if_main.mismatch_cnt, if_main.first_fail_lane,
                      if_main.first_fail_cycle};
                check($sformatf("main_cycle%0d", n_cycle), 64'(a), 64'(e.s_main));
                a = '{if_stop.state, if_stop.err_now, if_stop.err_sticky, if_stop.err_lane_mask,
                      if_stop.compare_cnt, if_stop.mismatch_cnt, if_stop.first_fail_lane,
                      if_stop.first_fail_cycle};
                check($sformatf("stop_cycle%0d", n_cycle), 64'(a), 64'(e.s_stop));
                a = '{if_small.state, if_small.err_now, if_small.err_sticky, if_small.err_lane_mask,
                      16'(if_small.compare_cnt), 16'(if_small.mismatch_cnt), if_small.first_fail_lane,
                      16'(if_small.first_fail_cycle)};
                check($sformatf("small_cycle%0d", n_cycle), 64'(a), 64'(e.s_small));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t sq[$];
        int    lag;
        beat_t sb;
        lag = 0;

        // Reset.
        t_reset = 1'b1;
        idle(3);
        t_reset = 1'b0;
        idle(1);
        check("reset_state", 64'(if_main.state), 64'd0);
        check("reset_compare_cnt", 64'(if_main.compare_cnt), 64'd0);

        // Identical streams, no skew.
        arm(0);
        lag_stream(0, 20);
        idle(2);
        check("t1_compare_cnt", 64'(if_main.compare_cnt), 64'd20);
        check("t1_mismatch_cnt", 64'(if_main.mismatch_cnt), 64'd0);
        check("t1_err_sticky", 64'(if_main.err_sticky), 64'd0);

        // Lane 2 data error on the fifth compare.
        arm(0);
        for (int k = 0; k < 10; k++) begin
            t_in_b = pattern(k);
            t_in_s = pattern(k);
            if (k == 4) begin
                t_in_b[23:16] = 8'hAB;
                t_in_s[23:16] = 8'hAA;
            end
            t_vb = 4'hF;
            t_vs = 4'hF;
            tick();
        end
        idle(2);
        check("t2_mask", 64'(if_main.err_lane_mask), 64'h4);
        check("t2_first_lane", 64'(if_main.first_fail_lane), 64'd2);
        check("t2_first_cycle", 64'(if_main.first_fail_cycle), 64'd4);
        check("t2_mismatch_cnt", 64'(if_main.mismatch_cnt), 64'd1);

        // Structural lags by 3: matched skew passes, skew 2 fails at once.
        arm(3);
        lag_stream(3, 10);
        idle(5);
        check("t3_skew3_sticky", 64'(if_main.err_sticky), 64'd0);
        check("t3_skew3_compare_cnt", 64'(if_main.compare_cnt), 64'd10);
        arm(2);
        lag_stream(3, 10);
        idle(5);
        check("t3_skew2_sticky", 64'(if_main.err_sticky), 64'd1);
        check("t3_skew2_first_lane", 64'(if_main.first_fail_lane), 64'd0);
        check("t3_skew2_first_cycle", 64'(if_main.first_fail_cycle), 64'd0);

        // Stop on fail: lanes 1 and 3 fail together on the fourth compare.
        arm(0);
        for (int k = 0; k < 7; k++) begin
            t_in_b = pattern(k);
            t_in_s = pattern(k);
            if (k == 3) t_in_s = t_in_s ^ 32'h0100_0100;
            t_vb = 4'hF;
            t_vs = 4'hF;
            tick();
        end
        idle(2);
        check("t4_stop_state", 64'(if_stop.state), 64'd3);
        check("t4_stop_mask", 64'(if_stop.err_lane_mask), 64'hA);
        check("t4_stop_first_lane", 64'(if_stop.first_fail_lane), 64'd1);
        check("t4_stop_compare_frozen", 64'(if_stop.compare_cnt), 64'd4);
        check("t4_main_compare_cnt", 64'(if_main.compare_cnt), 64'd7);
        t_enable = 1'b0;
        idle(2);
        check("t4_stop_idle", 64'(if_stop.state), 64'd0);

        // Saturation with a 4-bit counter.
        arm(0);
        for (int k = 0; k < 20; k++) begin
            t_in_b = pattern(k);
            t_vb   = 4'h0;
            t_in_s = pattern(k);
            t_vs   = 4'hF;
            tick();
        end
        idle(2);
        check("t5_small_compare_sat", 64'(if_small.compare_cnt), 64'd15);
        check("t5_small_mismatch_sat", 64'(if_small.mismatch_cnt), 64'd15);
        check("t5_main_mismatch_cnt", 64'(if_main.mismatch_cnt), 64'd20);

        // Reset mid-CHECK with errors latched, enable still high.
        arm(0);
        for (int k = 0; k < 3; k++) begin
            t_in_b = pattern(k); t_vb = 4'hF;
            t_in_s = ~pattern(k); t_vs = 4'hF;
            tick();
        end
        t_reset = 1'b1;
        tick();
        t_reset = 1'b0;
        idle(1);
        check("t6_reset_state", 64'(if_main.state), 64'd0);
        check("t6_reset_sticky", 64'(if_main.err_sticky), 64'd0);
        check("t6_reset_mask", 64'(if_main.err_lane_mask), 64'd0);
        check("t6_reset_mismatch", 64'(if_main.mismatch_cnt), 64'd0);
        lag_stream(0, 10);
        idle(2);
        check("t6_rerun_compare_cnt", 64'(if_main.compare_cnt), 64'd10);
        check("t6_rerun_sticky", 64'(if_main.err_sticky), 64'd0);

        // Randomised traffic: structural mostly lags by the armed skew, with
        // occasional corruption, valid flips, re-arms and resets.
        for (int n = 0; n < 600; n++) begin
            t_reset = ($urandom_range(0, 59) == 0);
            if (!t_enable) t_enable = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 39) == 0) t_enable = 1'b0;
            t_skew = 3'($urandom_range(0, 7));
            if (!t_reset && t_enable && m_st[0] == 0)
                lag = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : int'(t_skew);
            t_in_b = $urandom();
            t_vb   = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
            sq.push_back('{d: t_in_b, v: t_vb});
            if (sq.size() > 8) void'(sq.pop_front());
            sb = (sq.size() > lag) ? sq[sq.size() - 1 - lag] : '0;
            t_in_s = sb.d;
            t_vs   = sb.v;
            if ($urandom_range(0, 15) == 0) t_in_s = t_in_s ^ (32'd1 << $urandom_range(0, 31));
            if ($urandom_range(0, 31) == 0) t_vs = t_vs ^ 4'(1 << $urandom_range(0, 3));
            tick();
        end
        t_reset = 1'b0;
        idle(4);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
